// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, ALU opcode encoding and the
// ID/EX slot layout used by the pipeline register.
package core_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_SLL  = 4'b0010;
   localparam logic [3:0] ALU_SLT  = 4'b0011;
   localparam logic [3:0] ALU_SLTU = 4'b0100;
   localparam logic [3:0] ALU_XOR  = 4'b0101;
   localparam logic [3:0] ALU_SRL  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_OR   = 4'b1000;
   localparam logic [3:0] ALU_AND  = 4'b1001;
   localparam logic [3:0] ALU_LUI  = 4'b1010;

   typedef enum logic [1:0] {
      FWD_NONE  = 2'd0,
      FWD_EXMEM = 2'd1,
      FWD_MEMWB = 2'd2
   } fwd_sel_e;

   typedef struct packed {
      logic              valid;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   rs1_data;
      logic [XLEN-1:0]   rs2_data;
      logic [XLEN-1:0]   imm;
      logic [REG_AW-1:0] rs1_addr;
      logic [REG_AW-1:0] rs2_addr;
      logic [REG_AW-1:0] rd_addr;
      logic [3:0]        alu_ctrl;
      logic              src_a_pc;
      logic              src_b_imm;
      logic              reg_write;
      logic              mem_read;
   } id_ex_t;

   // x0 is hardwired to zero, so a producer targeting it never forwards.
   function automatic logic fwd_hit(input logic              reg_write,
                                    input logic [REG_AW-1:0] rd,
                                    input logic [REG_AW-1:0] rs);
      return reg_write && (rd != '0) && (rd == rs);
   endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select for one source register: EX/MEM result has
// priority over MEM/WB, otherwise the register-file read data passes through.
module fwd_mux
   import core_pkg::*;
(
   input  logic [REG_AW-1:0] rs_addr,
   input  logic [XLEN-1:0]   rs_data,
   input  logic [REG_AW-1:0] exmem_rd,
   input  logic              exmem_reg_write,
   input  logic [XLEN-1:0]   exmem_result,
   input  logic [REG_AW-1:0] memwb_rd,
   input  logic              memwb_reg_write,
   input  logic [XLEN-1:0]   memwb_result,
   output logic [XLEN-1:0]   value
);

   fwd_sel_e sel;

   always_comb begin
      sel = FWD_NONE;
      if (fwd_hit(exmem_reg_write, exmem_rd, rs_addr)) begin
         sel = FWD_EXMEM;
      end else if (fwd_hit(memwb_reg_write, memwb_rd, rs_addr)) begin
         sel = FWD_MEMWB;
      end
   end

   always_comb begin
      value = rs_data;
      case (sel)
         FWD_EXMEM: value = exmem_result;
         FWD_MEMWB: value = memwb_result;
         default:   value = rs_data;
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and ALU operand selection;
// also raises the load-use hazard that the pipeline controller acts on.
module id_ex_stage
   import core_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [XLEN-1:0]   id_rs1_data,
   input  logic [XLEN-1:0]   id_rs2_data,
   input  logic [REG_AW-1:0] id_rs1_addr,
   input  logic [REG_AW-1:0] id_rs2_addr,
   input  logic [REG_AW-1:0] id_rd_addr,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [3:0]        id_alu_ctrl,
   input  logic              id_src_a_pc,
   input  logic              id_src_b_imm,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic [REG_AW-1:0] exmem_rd,
   input  logic              exmem_reg_write,
   input  logic [XLEN-1:0]   exmem_result,
   input  logic [REG_AW-1:0] memwb_rd,
   input  logic              memwb_reg_write,
   input  logic [XLEN-1:0]   memwb_result,
   output logic              ex_valid,
   output logic [XLEN-1:0]   alu_a,
   output logic [XLEN-1:0]   alu_b,
   output logic [3:0]        alu_ctrl,
   output logic [XLEN-1:0]   ex_store_data,
   output logic [XLEN-1:0]   ex_pc,
   output logic [REG_AW-1:0] ex_rd,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              load_use_hazard
);

   id_ex_t slot;
   id_ex_t slot_in;
   logic [XLEN-1:0] fwd_rs1;
   logic [XLEN-1:0] fwd_rs2;

   always_comb begin
      slot_in           = '0;
      slot_in.valid     = id_valid;
      slot_in.pc        = id_pc;
      slot_in.rs1_data  = id_rs1_data;
      slot_in.rs2_data  = id_rs2_data;
      slot_in.imm       = id_imm;
      slot_in.rs1_addr  = id_rs1_addr;
      slot_in.rs2_addr  = id_rs2_addr;
      slot_in.rd_addr   = id_rd_addr;
      slot_in.alu_ctrl  = id_alu_ctrl;
      slot_in.src_a_pc  = id_src_a_pc;
      slot_in.src_b_imm = id_src_b_imm;
      slot_in.reg_write = id_reg_write;
      slot_in.mem_read  = id_mem_read;
   end

   // A flush only kills the slot; the payload is left as-is since nothing
   // downstream looks at it while valid is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot          <= '0;
         slot.alu_ctrl <= ALU_ADD;
      end else if (flush) begin
         slot.valid <= 1'b0;
      end else if (!stall) begin
         slot <= slot_in;
      end
   end

   fwd_mux u_fwd_rs1 (
      .rs_addr         (slot.rs1_addr),
      .rs_data         (slot.rs1_data),
      .exmem_rd        (exmem_rd),
      .exmem_reg_write (exmem_reg_write),
      .exmem_result    (exmem_result),
      .memwb_rd        (memwb_rd),
      .memwb_reg_write (memwb_reg_write),
      .memwb_result    (memwb_result),
      .value           (fwd_rs1)
   );

   fwd_mux u_fwd_rs2 (
      .rs_addr         (slot.rs2_addr),
      .rs_data         (slot.rs2_data),
      .exmem_rd        (exmem_rd),
      .exmem_reg_write (exmem_reg_write),
      .exmem_result    (exmem_result),
      .memwb_rd        (memwb_rd),
      .memwb_reg_write (memwb_reg_write),
      .memwb_result    (memwb_result),
      .value           (fwd_rs2)
   );

   always_comb begin
      ex_valid      = slot.valid;
      ex_pc         = slot.pc;
      ex_rd         = slot.rd_addr;
      ex_reg_write  = slot.valid & slot.reg_write;
      ex_mem_read   = slot.valid & slot.mem_read;
      alu_ctrl      = slot.valid ? slot.alu_ctrl : ALU_ADD;
      alu_a         = slot.src_a_pc  ? slot.pc  : fwd_rs1;
      alu_b         = slot.src_b_imm ? slot.imm : fwd_rs2;
      ex_store_data = fwd_rs2;
   end

   // Conservative: does not know whether the ID instruction reads rs1/rs2.
   always_comb begin
      load_use_hazard = ex_mem_read && (ex_rd != '0) && id_valid &&
                        ((ex_rd == id_rs1_addr) || (ex_rd == id_rs2_addr));
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: stimulus queues hand-computed expectations
// tagged with a cycle number; a negedge monitor pops and compares them.
module tb_id_ex_stage;
   import core_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              stall, flush, id_valid;
   logic [XLEN-1:0]   id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [REG_AW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic [3:0]        id_alu_ctrl;
   logic              id_src_a_pc, id_src_b_imm, id_reg_write, id_mem_read;
   logic [REG_AW-1:0] exmem_rd, memwb_rd;
   logic              exmem_reg_write, memwb_reg_write;
   logic [XLEN-1:0]   exmem_result, memwb_result;
   logic              ex_valid, ex_reg_write, ex_mem_read, load_use_hazard;
   logic [XLEN-1:0]   alu_a, alu_b, ex_store_data, ex_pc;
   logic [3:0]        alu_ctrl;
   logic [REG_AW-1:0] ex_rd;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
      .id_rs2_data(id_rs2_data), .id_rs1_addr(id_rs1_addr),
      .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr), .id_imm(id_imm),
      .id_alu_ctrl(id_alu_ctrl), .id_src_a_pc(id_src_a_pc),
      .id_src_b_imm(id_src_b_imm), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .exmem_rd(exmem_rd),
      .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
      .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
      .memwb_result(memwb_result), .ex_valid(ex_valid), .alu_a(alu_a),
      .alu_b(alu_b), .alu_ctrl(alu_ctrl), .ex_store_data(ex_store_data),
      .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .load_use_hazard(load_use_hazard)
   );

   always #5 clk = ~clk;

   localparam int S_VALID = 0, S_A = 1, S_B = 2, S_CTRL = 3, S_STORE = 4,
                  S_PC = 5, S_RD = 6, S_RW = 7, S_MR = 8, S_LUH = 9;

   typedef struct {
      int          cyc;
      string       name;
      int          sig;
      logic [31:0] exp;
   } chk_t;

   chk_t q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] actual(input int sig);
      case (sig)
         S_VALID: return {31'd0, ex_valid};
         S_A:     return alu_a;
         S_B:     return alu_b;
         S_CTRL:  return {28'd0, alu_ctrl};
         S_STORE: return ex_store_data;
         S_PC:    return ex_pc;
         S_RD:    return {27'd0, ex_rd};
         S_RW:    return {31'd0, ex_reg_write};
         S_MR:    return {31'd0, ex_mem_read};
         default: return {31'd0, load_use_hazard};
      endcase
   endfunction

   // Monitor: compares every expectation stamped with the current cycle.
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         chk_t c;
         logic [31:0] act;
         c = q.pop_front();
         n_cmp++;
         if (c.cyc < cyc) begin
            n_bad++;
            $display("FAIL %s: stale expectation (cycle %0d, now %0d)", c.name, c.cyc, cyc);
         end else begin
            act = actual(c.sig);
            if (act !== c.exp) begin
               n_bad++;
               $display("FAIL %s: got 0x%0h expected 0x%0h", c.name, act, c.exp);
            end
         end
      end
   end

   task automatic expect_val(input string name, input int sig, input logic [31:0] v);
      chk_t c;
      c.cyc = cyc; c.name = name; c.sig = sig; c.exp = v;
      q.push_back(c);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [31:0] pc,
                         input logic [4:0] rs1, input logic [31:0] d1,
                         input logic [4:0] rs2, input logic [31:0] d2,
                         input logic [4:0] rd, input logic [31:0] imm,
                         input logic [3:0] ctrl, input logic sa, input logic sb,
                         input logic rw, input logic mr);
      id_valid = v; id_pc = pc; id_rs1_addr = rs1; id_rs1_data = d1;
      id_rs2_addr = rs2; id_rs2_data = d2; id_rd_addr = rd; id_imm = imm;
      id_alu_ctrl = ctrl; id_src_a_pc = sa; id_src_b_imm = sb;
      id_reg_write = rw; id_mem_read = mr;
   endtask

   task automatic set_fwd(input logic [4:0] erd, input logic erw, input logic [31:0] eres,
                          input logic [4:0] wrd, input logic wrw, input logic [31:0] wres);
      exmem_rd = erd; exmem_reg_write = erw; exmem_result = eres;
      memwb_rd = wrd; memwb_reg_write = wrw; memwb_result = wres;
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0);
      set_fwd(0, 0, 0, 0, 0, 0);
      repeat (3) step();

      // reset state; present SUB x9 = x5 - x6
      rst_n = 1'b1;
      expect_val("rst_valid", S_VALID, 0);
      expect_val("rst_ctrl",  S_CTRL,  0);
      expect_val("rst_rw",    S_RW,    0);
      expect_val("rst_mr",    S_MR,    0);
      expect_val("rst_luh",   S_LUH,   0);
      set_id(1, 32'h40, 5, 7, 6, 3, 9, 0, ALU_SUB, 0, 0, 1, 0);

      step();
      expect_val("cap_valid", S_VALID, 1);
      expect_val("cap_a",     S_A,     7);
      expect_val("cap_b",     S_B,     3);
      expect_val("cap_ctrl",  S_CTRL,  4'b0001);
      expect_val("cap_store", S_STORE, 3);
      expect_val("cap_pc",    S_PC,    32'h40);
      expect_val("cap_rd",    S_RD,    9);
      expect_val("cap_rw",    S_RW,    1);
      stall = 1'b1;
      set_id(1, 32'h44, 1, 32'hAA, 2, 32'hBB, 3, 0, ALU_XOR, 0, 0, 1, 0);

      step();
      set_fwd(5, 1, 32'h11, 5, 1, 32'h22);
      expect_val("stall1_pc",   S_PC,   32'h40);
      expect_val("stall1_b",    S_B,    3);
      expect_val("stall1_ctrl", S_CTRL, 4'b0001);
      expect_val("fwd_exmem",   S_A,    32'h11);

      step();
      exmem_reg_write = 1'b0;
      expect_val("stall2_pc",  S_PC,    32'h40);
      expect_val("stall2_st",  S_STORE, 3);
      expect_val("fwd_memwb",  S_A,     32'h22);
      stall = 1'b0;
      set_id(1, 32'h80, 0, 32'h55, 8, 32'h66, 0, 0, ALU_AND, 0, 0, 0, 0);

      step();
      set_fwd(0, 1, 32'h11, 0, 1, 32'h22);
      expect_val("x0_nofwd_a", S_A,    32'h55);
      expect_val("x0_b",       S_B,    32'h66);
      expect_val("x0_ctrl",    S_CTRL, ALU_AND);
      expect_val("x0_rw",      S_RW,   0);
      expect_val("x0_pc",      S_PC,   32'h80);
      stall = 1'b1; flush = 1'b1;
      set_id(1, 32'hC0, 1, 1, 1, 1, 1, 0, ALU_OR, 0, 0, 1, 0);

      step();
      expect_val("flush_valid", S_VALID, 0);
      expect_val("flush_ctrl",  S_CTRL,  0);
      expect_val("flush_rw",    S_RW,    0);
      stall = 1'b0; flush = 1'b0;
      set_fwd(0, 0, 0, 0, 0, 0);
      set_id(1, 32'h100, 2, 32'h1000, 0, 0, 8, 4, ALU_ADD, 0, 1, 1, 1);

      step();
      set_id(1, 32'h104, 3, 0, 8, 0, 4, 0, ALU_ADD, 0, 0, 1, 0);
      expect_val("ld_mr",  S_MR,  1);
      expect_val("ld_a",   S_A,   32'h1000);
      expect_val("ld_b",   S_B,   4);
      expect_val("ld_rd",  S_RD,  8);
      expect_val("ld_luh", S_LUH, 1);
      flush = 1'b1;

      step();
      expect_val("ldfl_luh", S_LUH, 0);
      expect_val("ldfl_mr",  S_MR,  0);
      flush = 1'b0;
      set_id(1, 32'h108, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 1, 1, 1);

      step();
      set_id(1, 32'h200, 0, 0, 0, 0, 7, 32'h12345000, ALU_LUI, 0, 1, 1, 0);
      expect_val("ldx0_luh", S_LUH, 0);
      expect_val("ldx0_mr",  S_MR,  1);
      expect_val("ldx0_rw",  S_RW,  1);

      step();
      expect_val("lui_b",    S_B,    32'h12345000);
      expect_val("lui_ctrl", S_CTRL, 4'b1010);
      expect_val("lui_rd",   S_RD,   7);
      expect_val("lui_mr",   S_MR,   0);
      set_id(1, 32'h100, 4, 32'hDEAD, 0, 0, 6, 32'h2000, ALU_ADD, 1, 1, 1, 0);

      step();
      expect_val("auipc_a",    S_A,    32'h100);
      expect_val("auipc_b",    S_B,    32'h2000);
      expect_val("auipc_ctrl", S_CTRL, 0);
      set_id(1, 32'h104, 2, 32'h10, 3, 32'h33, 0, 8, ALU_ADD, 0, 1, 0, 0);

      step();
      set_fwd(3, 1, 32'hAB, 2, 1, 32'hCD);
      expect_val("st_a_memwb",  S_A,     32'hCD);
      expect_val("st_b_imm",    S_B,     8);
      expect_val("st_data_fwd", S_STORE, 32'hAB);

      step();
      rst_n = 1'b0;
      expect_val("mid_rst_valid", S_VALID, 0);
      expect_val("mid_rst_ctrl",  S_CTRL,  0);
      expect_val("mid_rst_rw",    S_RW,    0);
      expect_val("mid_rst_a",     S_A,     0);
      set_id(1, 32'h300, 1, 32'h77, 0, 0, 5, 0, ALU_OR, 0, 0, 1, 0);

      step();
      rst_n = 1'b1;
      expect_val("post_rst_valid", S_VALID, 0);

      step();
      expect_val("post_cap_valid", S_VALID, 1);
      expect_val("post_cap_ctrl",  S_CTRL,  ALU_OR);
      expect_val("post_cap_a",     S_A,     32'h77);
      expect_val("post_cap_rd",    S_RD,    5);
      expect_val("post_cap_rw",    S_RW,    1);

      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      #2;
      while (q.size() > 0) begin
         chk_t c;
         c = q.pop_front();
         n_cmp++;
         n_bad++;
         $display("FAIL %s: never compared (cycle %0d)", c.name, c.cyc);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
